soe_to_so_12_hrx4_nir_nol: RTL and testbench
============================================

Name: soe_to_so_12_hrx4_nir_nol

Overview:
- Downstream reassembly stage for the 12-element matrix-add datapath when run at hardware-reuse factor 4.
- Accepts one 3-element group per beat from the upstream series stage, over 4 beats (series 0..3).
- Presents all 12 elements as one stable parallel vector with a single-cycle ready pulse.
- Sits between the reuse-factor-4 adder lanes and any consumer needing the full 12-element result.

Parameters:
- IN_WIDTH, 10, signed element width in bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  global advance qualifier.
- inReady  in  1  group valid; a beat is accepted when enable & inReady.
- inSeries  in  2  upstream series index of the current group (0..3).
- B0, B1, B2  in  IN_WIDTH each  signed group elements.
- newOutSeriesStart  out  1  registered; high when the next accepted group fills slots 0..2.
- O0..O11  out  IN_WIDTH each  signed registered output vector.
- OutReady  out  1  registered single-cycle pulse; the new vector is valid.
- earlyOutReady  out  1  combinational; high in the cycle the final group (count 3) is accepted.
- seriesError  out  1  sticky; the upstream index disagreed with the internal count.

Behaviour:
- Reset (reset low, asynchronous, dominates everything):
  - count=0, newOutSeriesStart=1, OutReady=0, seriesError=0.
  - O0..O11=0; staging registers=0.
- Internal state:
  - 2-bit count 0..3.
  - Staging registers S0..S8 for series 0..2.
- Accepted beat with count=k<3:
  - Write B0,B1,B2 to staging S(3k),S(3k+1),S(3k+2); count<=k+1.
- Accepted beat with count=3:
  - Load O0..O8 from S0..S8 and O9..O11 from B0..B2 in the same edge.
  - count<=0; OutReady<=1 for exactly one cycle.
- Output stability: O changes only on the completing edge. Between OutReady pulses O holds the previous vector, including during partial collection.
- Latency: OutReady and the new O are visible 1 cycle after the count-3 beat is accepted.
- earlyOutReady = enable & inReady & (count==3), with no register.
- newOutSeriesStart <= (next count==0). It is 1 after reset and after each completion, 0 otherwise.
- enable low:
  - No state change; inReady is ignored.
  - An OutReady pulse already scheduled still deasserts after one cycle.
- Back-to-back vectors: count=3 accepted on cycle t and count=0 accepted on t+1 are legal. OutReady is high on t+1 and S0..S2 are written on t+1 with no stall.
- Sustained input at 1 group/cycle gives 1 vector per 4 cycles. There is no backpressure input; the consumer must take O within 4 accepted beats.
- Reset asserted mid-series discards the partial staging contents; the next accepted beat is treated as series 0.
- Values pass through unmodified: no arithmetic and no width change.

Optional Feature:
- Macro: SOE_SERIES_CHECK_EN.
- Defined:
  - On each accepted beat, if inSeries != count, seriesError <= 1 and stays 1 until reset.
  - Data is still placed by the internal count; there is no resync.
- Undefined:
  - inSeries is ignored and seriesError is tied to 0.
  - No compare logic is generated.

Decomposition:
- Shared package:
  - Constants N_ELEM=12, HR=4, GROUP=3, SERIES_W=2.
  - Signed element typedef parameterised by IN_WIDTH.
  - Slot-base function (3*k).
- Sub-module soe_series_counter:
  - Mod-HR counter with advance input, wrap flag (count==HR-1 & advance) and registered start flag.
  - Asynchronous active-low reset.
  - Reused by the matching upstream serialiser.

Test Plan:
- Reset release, then groups (1,2,3),(4,5,6),(7,8,9),(10,11,12) with inSeries 0..3 on 4 consecutive cycles -> earlyOutReady high on cycle 4; OutReady high only on cycle 5; O0..O11=1..12.
- Same groups with enable low on cycle 2 -> collection pauses and OutReady arrives one cycle later. Between pulses O holds the prior vector, checked while a second vector of negatives (-1..-12) is collected.
- Two vectors back-to-back at 1 group/cycle -> OutReady pulses exactly 4 cycles apart; second O = -1..-12; newOutSeriesStart high on cycles 1, 5, 9 only.
- Boundary values B=511 and B=-512 with IN_WIDTH=10 -> passed through bit-exact to the matching O slots.
- reset pulsed low mid-cycle after 2 accepted groups -> all outputs 0 immediately; the next 4 beats produce a clean vector; no stale staging data.
- With SOE_SERIES_CHECK_EN: inSeries=2 sent on the second beat -> seriesError=1 from the next edge until reset, and the vector is still assembled by count. Without the macro, the same stimulus leaves seriesError at 0.

Source files
------------

// File: rtl/soe_to_so_12_hrx4_nir_nol_pkg.sv
// ---------------------------------------------------------------------------
// soe_to_so_12_hrx4_nir_nol_pkg
// Shared constants and helpers for the reuse-factor-4 series/parallel
// reassembly stage and its matching upstream serialiser.
//   N_ELEM   : elements in one full vector (12)
//   HR       : hardware-reuse factor, beats per vector (4)
//   GROUP    : elements carried per beat (3)
//   SERIES_W : width of the series index / beat counter (2)
//   STAGE_N  : elements held in staging before the final beat (9)
// ---------------------------------------------------------------------------
package soe_to_so_12_hrx4_nir_nol_pkg;

    localparam int N_ELEM   = 12;
    localparam int HR       = 4;
    localparam int GROUP    = 3;
    localparam int SERIES_W = 2;
    localparam int STAGE_N  = GROUP * (HR - 1);

    // Default element type at the nominal width. Modules that take an
    // IN_WIDTH parameter declare their own elem_t of the same shape.
    localparam int IN_WIDTH_DEFAULT = 10;
    typedef logic signed [IN_WIDTH_DEFAULT-1:0] elem_default_t;

    // First staging slot written by series index k (3*k).
    function automatic logic [3:0] slot_base(input logic [SERIES_W-1:0] k);
        return 4'(k) * 4'(GROUP);
    endfunction

endpackage

// File: rtl/soe_to_so_12_hrx4_nir_nol_series_counter.sv
// ---------------------------------------------------------------------------
// soe_series_counter
// Mod-HR beat counter shared by the serialiser and the reassembly stage.
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   advance in   count one beat this cycle
//   count   out  current beat index 0..HR_N-1 (this is the FSM state)
//   wrap    out  combinational: last beat of the series is advancing now
//   start   out  registered: the next advancing beat is beat 0
// ---------------------------------------------------------------------------
module soe_series_counter
    import soe_to_so_12_hrx4_nir_nol_pkg::*;
#(
    parameter int HR_N = HR,
    parameter int CW   = SERIES_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          start
);

    assign wrap = advance && (count == CW'(HR_N - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            start <= 1'b1;
        end else if (advance) begin
            count <= wrap ? '0 : count + CW'(1);
            // Next count is zero exactly when this beat wraps.
            start <= wrap;
        end
    end

endmodule

// File: rtl/soe_to_so_12_hrx4_nir_nol.sv
// ---------------------------------------------------------------------------
// soe_to_so_12_hrx4_nir_nol
// Reassembles four 3-element groups (series 0..3) into one stable 12-element
// parallel vector, announced by a single-cycle OutReady pulse.
// Optional build macro: SOE_SERIES_CHECK_EN enables the sticky seriesError
// compare of inSeries against the internal count; otherwise seriesError is 0.
// Ports:
//   clk, reset          rising-edge clock, async active-low reset
//   enable, inReady     a beat is accepted when both are high
//   inSeries            upstream series index of the current group
//   B0..B2              group elements (signed, IN_WIDTH)
//   newOutSeriesStart   registered: next accepted group fills slots 0..2
//   O0..O11             registered output vector, changes only on completion
//   OutReady            registered one-cycle pulse: new vector on O
//   earlyOutReady       combinational: final group accepted this cycle
//   seriesError         sticky series index mismatch flag
// Handshake: no backpressure. A beat moves when enable & inReady; OutReady is
// a one-cycle strobe and the consumer must take O within 4 accepted beats.
// ---------------------------------------------------------------------------
module soe_to_so_12_hrx4_nir_nol
    import soe_to_so_12_hrx4_nir_nol_pkg::*;
#(
    parameter int IN_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       inReady,
    input  logic [SERIES_W-1:0]        inSeries,
    input  logic signed [IN_WIDTH-1:0] B0,
    input  logic signed [IN_WIDTH-1:0] B1,
    input  logic signed [IN_WIDTH-1:0] B2,
    output logic                       newOutSeriesStart,
    output logic signed [IN_WIDTH-1:0] O0,
    output logic signed [IN_WIDTH-1:0] O1,
    output logic signed [IN_WIDTH-1:0] O2,
    output logic signed [IN_WIDTH-1:0] O3,
    output logic signed [IN_WIDTH-1:0] O4,
    output logic signed [IN_WIDTH-1:0] O5,
    output logic signed [IN_WIDTH-1:0] O6,
    output logic signed [IN_WIDTH-1:0] O7,
    output logic signed [IN_WIDTH-1:0] O8,
    output logic signed [IN_WIDTH-1:0] O9,
    output logic signed [IN_WIDTH-1:0] O10,
    output logic signed [IN_WIDTH-1:0] O11,
    output logic                       OutReady,
    output logic                       earlyOutReady,
    output logic                       seriesError
);

    typedef logic signed [IN_WIDTH-1:0] elem_t;

    logic                accept;
    logic [SERIES_W-1:0] count;
    logic                wrap;
    logic [3:0]          base;

    elem_t stage [STAGE_N];
    elem_t o_vec [N_ELEM];

    assign accept = enable & inReady;

    soe_series_counter #(
        .HR_N (HR),
        .CW   (SERIES_W)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .advance (accept),
        .count   (count),
        .wrap    (wrap),
        .start   (newOutSeriesStart)
    );

    // wrap already includes the accept qualifier and count==3.
    assign earlyOutReady = wrap;
    assign base          = slot_base(count);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGE_N; i++) stage[i] <= '0;
            for (int i = 0; i < N_ELEM; i++)  o_vec[i] <= '0;
            OutReady <= 1'b0;
        end else begin
            // Registered every cycle so a pulse clears even with enable low.
            OutReady <= wrap;
            if (accept) begin
                if (!wrap) begin
                    stage[base]        <= B0;
                    stage[base + 4'd1] <= B1;
                    stage[base + 4'd2] <= B2;
                end else begin
                    // Completing beat: staged 0..8 plus the live group.
                    for (int i = 0; i < STAGE_N; i++) o_vec[i] <= stage[i];
                    o_vec[STAGE_N]     <= B0;
                    o_vec[STAGE_N + 1] <= B1;
                    o_vec[STAGE_N + 2] <= B2;
                end
            end
        end
    end

    assign O0  = o_vec[0];
    assign O1  = o_vec[1];
    assign O2  = o_vec[2];
    assign O3  = o_vec[3];
    assign O4  = o_vec[4];
    assign O5  = o_vec[5];
    assign O6  = o_vec[6];
    assign O7  = o_vec[7];
    assign O8  = o_vec[8];
    assign O9  = o_vec[9];
    assign O10 = o_vec[10];
    assign O11 = o_vec[11];

`ifdef SOE_SERIES_CHECK_EN
    // Flag only; data placement keeps following the internal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seriesError <= 1'b0;
        end else if (accept && (inSeries != count)) begin
            seriesError <= 1'b1;
        end
    end
`else
    assign seriesError = 1'b0;
    logic unused_series;
    assign unused_series = ^inSeries;
`endif

endmodule

// File: tb/tb_soe_to_so_12_hrx4_nir_nol.sv
module tb_soe_to_so_12_hrx4_nir_nol;

  localparam int W  = 10;
  localparam int VW = 12 * W;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                enable = 1'b0;
  logic                inReady = 1'b0;
  logic [1:0]          inSeries = 2'd0;
  logic signed [W-1:0] B0 = '0, B1 = '0, B2 = '0;
  logic                newOutSeriesStart, OutReady, earlyOutReady, seriesError;
  logic signed [W-1:0] O0, O1, O2, O3, O4, O5, O6, O7, O8, O9, O10, O11;

  soe_to_so_12_hrx4_nir_nol #(.IN_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .inReady(inReady),
    .inSeries(inSeries), .B0(B0), .B1(B1), .B2(B2),
    .newOutSeriesStart(newOutSeriesStart),
    .O0(O0), .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5),
    .O6(O6), .O7(O7), .O8(O8), .O9(O9), .O10(O10), .O11(O11),
    .OutReady(OutReady), .earlyOutReady(earlyOutReady),
    .seriesError(seriesError)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [VW-1:0] exp_q[$];
  int            cyc_q[$];
  int            errors = 0;
  int            checks = 0;
  int            tb_count = 0;
  logic          exp_serr = 1'b0;
  logic [VW-1:0] o_now;
  logic [VW-1:0] last_o = '0;

  assign o_now = {O11, O10, O9, O8, O7, O6, O5, O4, O3, O2, O1, O0};

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // monitor: pops an expected vector and its expected cycle on every OutReady
  always @(negedge clk) begin
    logic [VW-1:0] e;
    int            c;
    if (!reset) begin
      check("reset_o", o_now, '0);
      check("reset_outready", {{(VW-1){1'b0}}, OutReady}, '0);
      last_o = '0;
    end else if (OutReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_outready @cycle %0d: got pulse expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("vector", o_now, e);
        check("pulse_cycle", VW'(cyc), VW'(c));
      end
      last_o = o_now;
    end else begin
      check("o_hold", o_now, last_o);
    end
  end

  // driver: one cycle with the given inputs
  task automatic beat(input logic en, input logic rdy, input logic [1:0] ser,
                      input int v0, input int v1, input int v2);
    logic acc;
    enable   = en;
    inReady  = rdy;
    inSeries = ser;
    B0 = v0[W-1:0];
    B1 = v1[W-1:0];
    B2 = v2[W-1:0];
    acc = en && rdy;
    @(negedge clk);
    check("early_out_ready", {{(VW-1){1'b0}}, earlyOutReady}, VW'(acc && tb_count == 3));
    check("new_series_start", {{(VW-1){1'b0}}, newOutSeriesStart}, VW'(tb_count == 0));
    check("series_error", {{(VW-1){1'b0}}, seriesError}, VW'(exp_serr));
    @(posedge clk);
    #1;
    if (acc) begin
`ifdef SOE_SERIES_CHECK_EN
      if (int'(ser) != tb_count) exp_serr = 1'b1;
`endif
      if (tb_count == 3) begin
        cyc_q.push_back(cyc);
        tb_count = 0;
      end else begin
        tb_count++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 2'd0, 0, 0, 0);
  endtask

  // send a full vector; gap_at inserts an enable-low cycle (inReady high)
  // before that beat, bad_at sends inSeries=2 on that beat
  task automatic send_vec(input int v[12], input int gap_at, input int bad_at);
    logic [VW-1:0] e;
    for (int i = 0; i < 12; i++) e[i*W +: W] = v[i][W-1:0];
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) begin
      if (k == gap_at) beat(1'b0, 1'b1, 2'd3, 77, 88, 99);
      beat(1'b1, 1'b1, (k == bad_at) ? 2'd2 : 2'(k), v[3*k], v[3*k+1], v[3*k+2]);
    end
  endtask

  int v_pos[12];
  int v_neg[12];
  int v_bnd[12];
  int v_clean[12];

  initial begin
    v_pos   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    v_neg   = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10, -11, -12};
    v_bnd   = '{511, -512, 511, -512, 0, -1, 1, 511, -512, -512, 511, 0};
    v_clean = '{100, 101, 102, 103, 104, 105, 106, 107, 108, 109, 110, 111};

    // reset state
    repeat (3) @(negedge clk);
    check("reset_start", {{(VW-1){1'b0}}, newOutSeriesStart}, VW'(1));
    check("reset_early", {{(VW-1){1'b0}}, earlyOutReady}, '0);
    check("reset_serr", {{(VW-1){1'b0}}, seriesError}, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // basic vector on 4 consecutive cycles
    send_vec(v_pos, -1, -1);
    idle(2);

    // enable-low pause on the second beat, then negatives with O held
    send_vec(v_pos, 1, -1);
    idle(1);
    send_vec(v_neg, -1, -1);
    idle(2);

    // back-to-back vectors, then enable low right after the completion
    send_vec(v_pos, -1, -1);
    send_vec(v_neg, -1, -1);
    beat(1'b0, 1'b1, 2'd0, 5, 5, 5);
    idle(1);

    // boundary values
    send_vec(v_bnd, -1, -1);
    idle(2);

    // wrong series index on the second beat
    send_vec(v_pos, -1, 1);
    idle(2);

    // reset mid-series after two accepted groups
    beat(1'b1, 1'b1, 2'd0, 21, 22, 23);
    beat(1'b1, 1'b1, 2'd1, 24, 25, 26);
    enable = 1'b0;
    inReady = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("midreset_o", o_now, '0);
    check("midreset_outready", {{(VW-1){1'b0}}, OutReady}, '0);
    check("midreset_start", {{(VW-1){1'b0}}, newOutSeriesStart}, VW'(1));
    check("midreset_serr", {{(VW-1){1'b0}}, seriesError}, '0);
    tb_count = 0;
    exp_serr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_vec(v_clean, -1, -1);
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_vectors: got %0d left expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
